// File: rtl/adc_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : adc_scan_ctrl
//  Description : Multi-channel scan controller for a 12-bit SPI ADC with an
//                address-ahead (pipelined) protocol. One dummy frame primes
//                the first channel address, then every frame returns the
//                conversion addressed in the previous frame. Optional
//                per-channel averaging of 2^AVG_LOG2 conversions.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_scan_ctrl #(
    parameter int NUM_CH     = 8,
    parameter int CLK_DIV    = 4,
    parameter int AVG_LOG2   = 0,
    parameter int CONTINUOUS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              start,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              adc_miso,
    output logic              adc_sclk,
    output logic              adc_cs_n,
    output logic              adc_mosi,
    output logic [11:0]       sample_data,
    output logic [2:0]        sample_ch,
    output logic              sample_valid,
    output logic              scan_done,
    output logic              busy
);

    localparam int         ACC_W     = 12 + AVG_LOG2;
    localparam logic [9:0] DIV_LAST  = 10'(CLK_DIV - 1);
    localparam logic [9:0] HOLD_LAST = 10'(4 * CLK_DIV - 1);
    localparam logic [1:0] REP_MAX   = 2'((1 << AVG_LOG2) - 1);
    localparam logic [3:0] LAST_BIT  = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CS_SETUP  = 3'd1,
        ST_SHIFT     = 3'd2,
        ST_FRAME_END = 3'd3,
        ST_CS_HOLD   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [9:0]         cnt_q, cnt_d;
    logic               half_q, half_d;          // 0 = SCLK low half, 1 = high half
    logic [3:0]         bit_q, bit_d;            // SCLK period index inside the frame
    logic [10:0]        rx_q, rx_d;              // last 11 bits received
    logic [NUM_CH-1:0]  mask_q, mask_d;
    // Conversion whose data arrives in the current frame
    logic [2:0]         cur_ch_q, cur_ch_d;
    logic [1:0]         cur_rep_q, cur_rep_d;
    logic               cur_valid_q, cur_valid_d; // low during the dummy frame
    // Conversion addressed by the current frame (returned in the next one)
    logic [2:0]         nxt_ch_q, nxt_ch_d;
    logic [1:0]         nxt_rep_q, nxt_rep_d;
    logic               nxt_valid_q, nxt_valid_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               sclk_q, sclk_d;
    logic               cs_n_q, cs_n_d;
    logic               mosi_q, mosi_d;
    logic [11:0]        sample_data_q, sample_data_d;
    logic [2:0]         sample_ch_q, sample_ch_d;
    logic               sample_valid_q, sample_valid_d;
    logic               scan_done_q, scan_done_d;
    logic               busy_q, busy_d;

    logic               scan_req;
    logic               tick;
    logic [11:0]        rx_word;
    logic [ACC_W-1:0]   acc_sum;
    logic [3:0]         first_ch;
    logic [3:0]         next_ch;
    logic [2:0]         frame_addr;

    // Lowest enabled channel at or above 'from'; MSB flags that one exists.
    function automatic logic [3:0] find_from(input logic [NUM_CH-1:0] m, input int from);
        logic [3:0] r;
        r = 4'b0000;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if ((k >= from) && m[k]) begin
                r = {1'b1, 3'(k)};
            end
        end
        return r;
    endfunction

    // DIN bit for SCLK period 'b': address A2..A0 occupy periods 2..4.
    function automatic logic addr_bit(input logic [3:0] b, input logic [2:0] a);
        logic r;
        case (b)
            4'd2:    r = a[2];
            4'd3:    r = a[1];
            4'd4:    r = a[0];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign scan_req   = (CONTINUOUS != 0) ? enable : start;
    assign tick       = (cnt_q == DIV_LAST);
    assign rx_word    = {rx_q, adc_miso};
    assign acc_sum    = ((cur_rep_q == 2'd0) ? '0 : acc_q) + ACC_W'(rx_word);
    assign first_ch   = find_from(ch_mask, 0);
    assign next_ch    = find_from(mask_q, int'(nxt_ch_q) + 1);
    assign frame_addr = nxt_valid_q ? nxt_ch_q : 3'd0;

    // Next-state, SPI waveform generation and result handling.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        half_d         = half_q;
        bit_d          = bit_q;
        rx_d           = rx_q;
        mask_d         = mask_q;
        cur_ch_d       = cur_ch_q;
        cur_rep_d      = cur_rep_q;
        cur_valid_d    = cur_valid_q;
        nxt_ch_d       = nxt_ch_q;
        nxt_rep_d      = nxt_rep_q;
        nxt_valid_d    = nxt_valid_q;
        acc_d          = acc_q;
        sclk_d         = sclk_q;
        cs_n_d         = cs_n_q;
        mosi_d         = mosi_q;
        sample_data_d  = sample_data_q;
        sample_ch_d    = sample_ch_q;
        sample_valid_d = 1'b0;
        scan_done_d    = 1'b0;
        busy_d         = busy_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (scan_req && (ch_mask != '0)) begin
                    state_d     = ST_CS_SETUP;
                    mask_d      = ch_mask;
                    cs_n_d      = 1'b0;
                    sclk_d      = 1'b1;
                    busy_d      = 1'b1;
                    cur_valid_d = 1'b0;
                    cur_ch_d    = 3'd0;
                    cur_rep_d   = 2'd0;
                    nxt_valid_d = 1'b1;
                    nxt_ch_d    = first_ch[2:0];
                    nxt_rep_d   = 2'd0;
                    acc_d       = '0;
                end
            end

            ST_CS_SETUP: begin
                cnt_d = cnt_q + 10'd1;
                if (tick) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    bit_d   = 4'd0;
                    half_d  = 1'b0;
                    sclk_d  = 1'b0;
                    mosi_d  = addr_bit(4'd0, frame_addr);
                end
            end

            ST_SHIFT: begin
                cnt_d = cnt_q + 10'd1;
                if (tick) begin
                    cnt_d = '0;
                    if (!half_q) begin
                        // Rising SCLK edge: capture DOUT
                        sclk_d = 1'b1;
                        half_d = 1'b1;
                        rx_d   = {rx_q[9:0], adc_miso};
                        if (bit_q == LAST_BIT) begin
                            state_d = ST_FRAME_END;
                            if (cur_valid_q) begin
                                if (cur_rep_q == REP_MAX) begin
                                    sample_valid_d = 1'b1;
                                    sample_data_d  = 12'(acc_sum >> AVG_LOG2);
                                    sample_ch_d    = cur_ch_q;
                                    scan_done_d    = !nxt_valid_q;
                                    acc_d          = '0;
                                end else begin
                                    acc_d = acc_sum;
                                end
                            end
                            // Pipeline advance: the addressed conversion becomes current
                            cur_valid_d = nxt_valid_q;
                            cur_ch_d    = nxt_ch_q;
                            cur_rep_d   = nxt_rep_q;
                            if (nxt_valid_q) begin
                                if (nxt_rep_q != REP_MAX) begin
                                    nxt_rep_d = nxt_rep_q + 2'd1;
                                end else begin
                                    nxt_rep_d   = 2'd0;
                                    nxt_valid_d = next_ch[3];
                                    nxt_ch_d    = next_ch[3] ? next_ch[2:0] : nxt_ch_q;
                                end
                            end
                        end
                    end else begin
                        // Falling SCLK edge: next period, update DIN
                        bit_d  = bit_q + 4'd1;
                        half_d = 1'b0;
                        sclk_d = 1'b0;
                        mosi_d = addr_bit(bit_q + 4'd1, frame_addr);
                    end
                end
            end

            // High half of the 16th SCLK period; chains straight into the next frame.
            ST_FRAME_END: begin
                cnt_d = cnt_q + 10'd1;
                if (tick) begin
                    cnt_d = '0;
                    if (cur_valid_q) begin
                        state_d = ST_SHIFT;
                        bit_d   = 4'd0;
                        half_d  = 1'b0;
                        sclk_d  = 1'b0;
                        mosi_d  = addr_bit(4'd0, frame_addr);
                    end else begin
                        state_d = ST_CS_HOLD;
                        cs_n_d  = 1'b1;
                        sclk_d  = 1'b1;
                        mosi_d  = 1'b0;
                    end
                end
            end

            ST_CS_HOLD: begin
                cnt_d = cnt_q + 10'd1;
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b1;
                mosi_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset forces the idle bus immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            half_q         <= 1'b0;
            bit_q          <= 4'd0;
            rx_q           <= '0;
            mask_q         <= '0;
            cur_ch_q       <= 3'd0;
            cur_rep_q      <= 2'd0;
            cur_valid_q    <= 1'b0;
            nxt_ch_q       <= 3'd0;
            nxt_rep_q      <= 2'd0;
            nxt_valid_q    <= 1'b0;
            acc_q          <= '0;
            sclk_q         <= 1'b1;
            cs_n_q         <= 1'b1;
            mosi_q         <= 1'b0;
            sample_data_q  <= 12'd0;
            sample_ch_q    <= 3'd0;
            sample_valid_q <= 1'b0;
            scan_done_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            half_q         <= half_d;
            bit_q          <= bit_d;
            rx_q           <= rx_d;
            mask_q         <= mask_d;
            cur_ch_q       <= cur_ch_d;
            cur_rep_q      <= cur_rep_d;
            cur_valid_q    <= cur_valid_d;
            nxt_ch_q       <= nxt_ch_d;
            nxt_rep_q      <= nxt_rep_d;
            nxt_valid_q    <= nxt_valid_d;
            acc_q          <= acc_d;
            sclk_q         <= sclk_d;
            cs_n_q         <= cs_n_d;
            mosi_q         <= mosi_d;
            sample_data_q  <= sample_data_d;
            sample_ch_q    <= sample_ch_d;
            sample_valid_q <= sample_valid_d;
            scan_done_q    <= scan_done_d;
            busy_q         <= busy_d;
        end
    end

    assign adc_sclk     = sclk_q;
    assign adc_cs_n     = cs_n_q;
    assign adc_mosi     = mosi_q;
    assign sample_data  = sample_data_q;
    assign sample_ch    = sample_ch_q;
    assign sample_valid = sample_valid_q;
    assign scan_done    = scan_done_q;
    assign busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_scan_ctrl
//  Description : Directed bench for adc_scan_ctrl. Three instances:
//                0 = continuous, no averaging; 1 = continuous, AVG_LOG2=2;
//                2 = single-shot (CONTINUOUS=0). Each has an SPI ADC model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_scan_ctrl;

    logic        clk;
    logic        rst_r  [3];
    logic        en_r   [3];
    logic        st_r   [3];
    logic [7:0]  mask_r [3];
    logic        sclk_w [3];
    logic        csn_w  [3];
    logic        mosi_w [3];
    logic        sv_w   [3];
    logic        done_w [3];
    logic        busy_w [3];
    logic [11:0] sd_w   [3];
    logic [2:0]  sc_w   [3];

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic        miso = 1'b0;
        logic        prev_csn = 1'b1;
        logic        prev_sclk = 1'b1;
        logic [15:0] tx = '0;
        logic [15:0] rx = '0;
        logic [11:0] val;
        logic [2:0]  addr_log [16];
        int          frame_idx = 0;
        int          rcnt = 0;
        int          rises = 0;
        int          cs_falls = 0;
        int          hold_cycles = 0;
        int          busy_cycles = 0;
        int          bad_timing = 0;
        logic [11:0] sd_log [$];
        logic [2:0]  sc_log [$];
        logic        dn_log [$];

        adc_scan_ctrl #(
            .NUM_CH    (8),
            .CLK_DIV   (4),
            .AVG_LOG2  ((g == 1) ? 2 : 0),
            .CONTINUOUS((g == 2) ? 0 : 1)
        ) u_dut (
            .clk         (clk),
            .reset       (rst_r[g]),
            .enable      (en_r[g]),
            .start       (st_r[g]),
            .ch_mask     (mask_r[g]),
            .adc_miso    (miso),
            .adc_sclk    (sclk_w[g]),
            .adc_cs_n    (csn_w[g]),
            .adc_mosi    (mosi_w[g]),
            .sample_data (sd_w[g]),
            .sample_ch   (sc_w[g]),
            .sample_valid(sv_w[g]),
            .scan_done   (done_w[g]),
            .busy        (busy_w[g])
        );

        // ADC model and output monitor, evaluated mid-cycle
        always @(negedge clk) begin
            logic rise16;
            rise16 = 1'b0;
            if (prev_csn && !csn_w[g]) begin
                cs_falls++;
                frame_idx   = 0;
                rcnt        = 0;
                rises       = 0;
                hold_cycles = 0;
            end
            if (!csn_w[g] && prev_sclk && !sclk_w[g]) begin
                if (rcnt == 0) begin
                    if (frame_idx == 0)
                        val = 12'hABC;
                    else if (g == 1)
                        val = 12'd100 + 12'(frame_idx - 1);
                    else
                        val = 12'h100 + {9'd0, addr_log[frame_idx - 1]};
                    tx = {4'hA, val};
                end
                miso = tx[15 - rcnt];
            end
            if (!csn_w[g] && !prev_sclk && sclk_w[g]) begin
                rx = {rx[14:0], mosi_w[g]};
                rcnt++;
                rises++;
                if (rcnt == 16) begin
                    if (frame_idx < 16) addr_log[frame_idx] = {rx[13], rx[12], rx[11]};
                    frame_idx++;
                    rcnt   = 0;
                    rise16 = 1'b1;
                end
            end
            if (csn_w[g] && busy_w[g]) hold_cycles++;
            if (busy_w[g]) busy_cycles++;
            if (sv_w[g]) begin
                sd_log.push_back(sd_w[g]);
                sc_log.push_back(sc_w[g]);
                dn_log.push_back(done_w[g]);
                if (!rise16) bad_timing++;
            end
            if (done_w[g] && !sv_w[g]) bad_timing++;
            prev_csn  = csn_w[g];
            prev_sclk = sclk_w[g];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_busy(input int g, input logic lvl, input int max, input string tag);
        int n;
        n = 0;
        while (busy_w[g] !== lvl && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, busy_w[g]}, {31'd0, lvl});
    endtask

    initial begin
        int n;
        int base;
        for (int i = 0; i < 3; i++) begin
            rst_r[i] = 1'b1; en_r[i] = 1'b0; st_r[i] = 1'b0; mask_r[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        // Reset state
        check("rst_cs_n",   csn_w[0], 1);
        check("rst_sclk",   sclk_w[0], 1);
        check("rst_mosi",   mosi_w[0], 0);
        check("rst_data",   sd_w[0], 0);
        check("rst_ch",     sc_w[0], 0);
        check("rst_valid",  sv_w[0], 0);
        check("rst_done",   done_w[0], 0);
        check("rst_busy",   busy_w[0], 0);
        for (int i = 0; i < 3; i++) rst_r[i] = 1'b0;
        en_r[2] = 1'b1;    // single-shot instance must ignore enable
        repeat (2) @(negedge clk);

        // Full mask, enable dropped mid-scan
        mask_r[0] = 8'hFF; en_r[0] = 1'b1;
        wait_busy(0, 1'b1, 5, "a_busy_rise");
        repeat (300) @(negedge clk);
        en_r[0] = 1'b0;
        wait_busy(0, 1'b0, 3000, "a_busy_fall");
        repeat (40) @(negedge clk);
        check("a_frames",   g_dut[0].frame_idx, 9);
        check("a_rises",    g_dut[0].rises, 144);
        check("a_scans",    g_dut[0].cs_falls, 1);
        check("a_nsamples", g_dut[0].sd_log.size(), 8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("a_data%0d", k), g_dut[0].sd_log[k], 12'h100 + 12'(k));
            check($sformatf("a_ch%0d", k),   g_dut[0].sc_log[k], k);
            check($sformatf("a_done%0d", k), g_dut[0].dn_log[k], (k == 7) ? 1 : 0);
        end
        check("a_hold",     g_dut[0].hold_cycles, 16);
        check("a_timing",   g_dut[0].bad_timing, 0);
        check("a_cs_idle",  csn_w[0], 1);
        check("a_busy_end", busy_w[0], 0);

        // Sparse mask 1010_0100
        base = g_dut[0].sd_log.size();
        mask_r[0] = 8'b1010_0100; en_r[0] = 1'b1;
        wait_busy(0, 1'b1, 5, "b_busy_rise");
        repeat (10) @(negedge clk);
        en_r[0] = 1'b0;
        mask_r[0] = 8'h01;   // must not affect the running scan
        wait_busy(0, 1'b0, 3000, "b_busy_fall");
        repeat (20) @(negedge clk);
        check("b_frames",   g_dut[0].frame_idx, 4);
        check("b_addr0",    g_dut[0].addr_log[0], 2);
        check("b_addr1",    g_dut[0].addr_log[1], 5);
        check("b_addr2",    g_dut[0].addr_log[2], 7);
        check("b_nsamples", g_dut[0].sd_log.size() - base, 3);
        check("b_ch0",   g_dut[0].sc_log[base],     2);
        check("b_ch1",   g_dut[0].sc_log[base + 1], 5);
        check("b_ch2",   g_dut[0].sc_log[base + 2], 7);
        check("b_data0", g_dut[0].sd_log[base],     12'h102);
        check("b_data2", g_dut[0].sd_log[base + 2], 12'h107);
        check("b_done1", g_dut[0].dn_log[base + 1], 0);
        check("b_done2", g_dut[0].dn_log[base + 2], 1);
        check("b_timing", g_dut[0].bad_timing, 0);

        // Reset during SCLK period 7 of frame 3
        mask_r[0] = 8'hFF; en_r[0] = 1'b1;
        n = 0;
        while (!(g_dut[0].frame_idx == 3 && g_dut[0].rcnt == 7) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("r_point_reached", (n < 3000) ? 1 : 0, 1);
        rst_r[0] = 1'b1;
        #1;
        check("r_cs_n",  csn_w[0], 1);
        check("r_sclk",  sclk_w[0], 1);
        check("r_mosi",  mosi_w[0], 0);
        check("r_valid", sv_w[0], 0);
        check("r_busy",  busy_w[0], 0);
        check("r_data",  sd_w[0], 0);
        @(negedge clk);
        @(negedge clk);
        base = g_dut[0].sd_log.size();
        rst_r[0] = 1'b0;
        wait_busy(0, 1'b1, 10, "r_busy_rise");
        n = 0;
        while (g_dut[0].sd_log.size() == base && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("r_sample_seen", (n < 3000) ? 1 : 0, 1);
        check("r_first_ch",   g_dut[0].sc_log[base], 0);
        check("r_first_data", g_dut[0].sd_log[base], 12'h100);
        check("r_dummy_frame", g_dut[0].frame_idx, 2);
        en_r[0] = 1'b0;
        wait_busy(0, 1'b0, 3000, "r_busy_fall");
        check("r_timing", g_dut[0].bad_timing, 0);

        // Averaging of four conversions on channel 0
        mask_r[1] = 8'h01; en_r[1] = 1'b1;
        wait_busy(1, 1'b1, 5, "v_busy_rise");
        repeat (10) @(negedge clk);
        en_r[1] = 1'b0;
        wait_busy(1, 1'b0, 3000, "v_busy_fall");
        repeat (20) @(negedge clk);
        check("v_nsamples", g_dut[1].sd_log.size(), 1);
        check("v_data",     g_dut[1].sd_log[0], 12'd101);
        check("v_ch",       g_dut[1].sc_log[0], 0);
        check("v_done",     g_dut[1].dn_log[0], 1);
        check("v_frames",   g_dut[1].frame_idx, 5);
        check("v_timing",   g_dut[1].bad_timing, 0);

        // Single-shot: zero mask then mask 03
        st_r[2] = 1'b1;
        @(negedge clk);
        st_r[2] = 1'b0;
        repeat (40) @(negedge clk);
        check("s_zero_busy", g_dut[2].busy_cycles, 0);
        check("s_zero_cs",   g_dut[2].cs_falls, 0);
        check("s_zero_csn",  csn_w[2], 1);
        mask_r[2] = 8'h03;
        st_r[2] = 1'b1;
        @(negedge clk);
        st_r[2] = 1'b0;
        wait_busy(2, 1'b1, 5, "s_busy_rise");
        wait_busy(2, 1'b0, 3000, "s_busy_fall");
        repeat (200) @(negedge clk);
        check("s_scans",    g_dut[2].cs_falls, 1);
        check("s_nsamples", g_dut[2].sd_log.size(), 2);
        check("s_data1",    g_dut[2].sd_log[1], 12'h101);
        check("s_ch1",      g_dut[2].sc_log[1], 1);
        check("s_done1",    g_dut[2].dn_log[1], 1);
        check("s_idle",     busy_w[2], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
